// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: validates moves, alternates turns, drives the 9-cell array, detects win/draw, forfeits idle turns.
// Latency: move_req at edge E -> move_ack/move_err/cell_set after E, CHECK after E+1, result or next PLAY after E+2.
// Backpressure: none; move_req is only looked at in PLAY and is silently ignored in every other state.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   new_game             synchronous restart, wins over everything else
//   move_req, move_pos   move strobe and row-major cell index 0..8
//   move_ack, move_err   one-cycle accept / reject pulses
//   cell_set             one-hot set lines, high only during the WAIT cycle
//   cell_clear           clear line to all cells, high while in CLEAR
//   cell_set_symbol      symbol written by cell_set (the current turn)
//   cell_valid           per-cell occupied flags from the array
//   cell_symbol          per-cell symbol bits from the array
//   turn, move_count     player to move and accepted moves this game
//   timeout              one-cycle pulse when a turn is forfeited
//   game_over            high in DONE
//   winner_valid, winner a line was completed, and by which symbol
//   win_lines            completed lines: rows [2:0], cols [5:3], diag 0-4-8 [6], diag 2-4-6 [7]
module ttt_game_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_req,
  input  logic [3:0] move_pos,
  output logic       move_ack,
  output logic       move_err,
  output logic [8:0] cell_set,
  output logic       cell_clear,
  output logic       cell_set_symbol,
  input  logic [8:0] cell_valid,
  input  logic [8:0] cell_symbol,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       timeout,
  output logic       game_over,
  output logic       winner_valid,
  output logic       winner,
  output logic [7:0] win_lines
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_PLAY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state;
  logic [TO_W-1:0] to_cnt;

  // Widened copies so an out-of-range move_pos (9..15) can be indexed safely.
  logic [15:0] valid_ext;
  logic [15:0] pos_oh;
  logic        pos_ok;
  logic        legal;
  logic        to_hit;
  logic [8:0]  mine;
  logic [7:0]  line_mask;

  assign valid_ext = {7'd0, cell_valid};
  assign pos_oh    = 16'd1 << move_pos;
  assign pos_ok    = (move_pos <= 4'd8);
  assign legal     = move_req && pos_ok && !valid_ext[move_pos];
  assign to_hit    = TO_EN && (to_cnt == TO_LAST);

  // Cells owned by the player whose move is being checked.
  assign mine = cell_valid & ~(cell_symbol ^ {9{turn}});

  assign line_mask[0] = mine[0] & mine[1] & mine[2];
  assign line_mask[1] = mine[3] & mine[4] & mine[5];
  assign line_mask[2] = mine[6] & mine[7] & mine[8];
  assign line_mask[3] = mine[0] & mine[3] & mine[6];
  assign line_mask[4] = mine[1] & mine[4] & mine[7];
  assign line_mask[5] = mine[2] & mine[5] & mine[8];
  assign line_mask[6] = mine[0] & mine[4] & mine[8];
  assign line_mask[7] = mine[2] & mine[4] & mine[6];

  // Moore outputs: the array is held clear for the whole CLEAR state, reset included.
  assign cell_clear      = (state == S_CLEAR);
  assign cell_set_symbol = turn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CLEAR;
      turn         <= 1'b0;
      move_count   <= 4'd0;
      to_cnt       <= '0;
      cell_set     <= 9'd0;
      move_ack     <= 1'b0;
      move_err     <= 1'b0;
      timeout      <= 1'b0;
      game_over    <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      win_lines    <= 8'd0;
    end else begin
      // Pulses and the set lines are single-cycle by default.
      cell_set <= 9'd0;
      move_ack <= 1'b0;
      move_err <= 1'b0;
      timeout  <= 1'b0;

      if (new_game) begin
        // Restart wins over any pending move, timeout or result. A move
        // already presented during WAIT still lands, but CLEAR wipes it.
        state        <= S_CLEAR;
        turn         <= 1'b0;
        move_count   <= 4'd0;
        to_cnt       <= '0;
        game_over    <= 1'b0;
        winner_valid <= 1'b0;
        winner       <= 1'b0;
        win_lines    <= 8'd0;
      end else begin
        case (state)
          S_CLEAR: begin
            state        <= S_PLAY;
            turn         <= 1'b0;
            move_count   <= 4'd0;
            to_cnt       <= '0;
            game_over    <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            win_lines    <= 8'd0;
          end

          S_PLAY: begin
            if (legal) begin
              // A legal move on the last allowed cycle beats the timeout.
              state    <= S_WAIT;
              cell_set <= pos_oh[8:0];
              move_ack <= 1'b1;
              to_cnt   <= '0;
            end else begin
              move_err <= move_req;
              // A rejected move does not buy extra time: the counter keeps running.
              if (to_hit) begin
                timeout <= 1'b1;
                turn    <= ~turn;
                to_cnt  <= '0;
              end else if (TO_EN) begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
          end

          S_WAIT: begin
            move_count <= move_count + 4'd1;
            state      <= S_CHECK;
          end

          S_CHECK: begin
            // A completed line takes precedence over the ninth-move draw.
            if (|line_mask) begin
              state        <= S_DONE;
              game_over    <= 1'b1;
              winner_valid <= 1'b1;
              winner       <= turn;
              win_lines    <= line_mask;
            end else if (move_count == 4'd9) begin
              state     <= S_DONE;
              game_over <= 1'b1;
            end else begin
              turn  <= ~turn;
              state <= S_PLAY;
            end
          end

          S_DONE: begin
            // Everything holds until new_game or reset.
          end

          default: state <= S_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

  localparam int T = 8;

  localparam int P_CLEAR = 0;
  localparam int P_PLAY  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_CHECK = 3;
  localparam int P_DONE  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       move_req;
  logic [3:0] move_pos;
  logic       move_ack;
  logic       move_err;
  logic [8:0] cell_set;
  logic       cell_clear;
  logic       cell_set_symbol;
  logic [8:0] cell_valid;
  logic [8:0] cell_symbol;
  logic       turn;
  logic [3:0] move_count;
  logic       timeout;
  logic       game_over;
  logic       winner_valid;
  logic       winner;
  logic [7:0] win_lines;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .move_req(move_req),
    .move_pos(move_pos), .move_ack(move_ack), .move_err(move_err),
    .cell_set(cell_set), .cell_clear(cell_clear), .cell_set_symbol(cell_set_symbol),
    .cell_valid(cell_valid), .cell_symbol(cell_symbol), .turn(turn),
    .move_count(move_count), .timeout(timeout), .game_over(game_over),
    .winner_valid(winner_valid), .winner(winner), .win_lines(win_lines)
  );

  // The 9 storage cells: clear wins, otherwise latch on the first set only.
  always @(posedge clk) begin
    if (cell_clear) begin
      cell_valid  <= 9'd0;
      cell_symbol <= 9'd0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (cell_set[i] && !cell_valid[i]) begin
          cell_valid[i]  <= 1'b1;
          cell_symbol[i] <= cell_set_symbol;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int board [9];
  int m_ph, m_turn, m_cnt, m_pend, m_left;
  bit e_ack, e_err, e_to, e_over, e_wv, e_w;
  logic [8:0] e_set;
  logic [7:0] e_wl;

  function automatic logic [7:0] lines_of(input int who);
    logic [7:0] m;
    m = 8'd0;
    for (int l = 0; l < 8; l++)
      if (board[lines[l][0]] == who && board[lines[l][1]] == who && board[lines[l][2]] == who)
        m[l] = 1'b1;
    return m;
  endfunction

  task automatic model_reset;
    m_ph = P_CLEAR; m_turn = 0; m_cnt = 0; m_pend = 0; m_left = T;
    e_ack = 0; e_err = 0; e_to = 0; e_set = 9'd0;
    e_over = 0; e_wv = 0; e_w = 0; e_wl = 8'd0;
    for (int i = 0; i < 9; i++) board[i] = -1;
  endtask

  task automatic model_edge(input bit ng, input bit req, input logic [3:0] pos);
    int  pre, p;
    bit  lg;
    logic [7:0] wl;
    pre = m_ph;
    e_ack = 0; e_err = 0; e_to = 0; e_set = 9'd0;
    if (pre == P_WAIT) board[m_pend] = m_turn;
    if (pre == P_CLEAR) for (int i = 0; i < 9; i++) board[i] = -1;
    if (ng) begin
      m_ph = P_CLEAR; m_turn = 0; m_cnt = 0; m_left = T;
      e_over = 0; e_wv = 0; e_w = 0; e_wl = 8'd0;
    end else begin
      case (pre)
        P_CLEAR: begin
          m_ph = P_PLAY; m_turn = 0; m_cnt = 0; m_left = T;
          e_over = 0; e_wv = 0; e_w = 0; e_wl = 8'd0;
        end
        P_PLAY: begin
          p  = int'(pos);
          lg = req && (p <= 8);
          if (lg) lg = (board[p] < 0);
          if (lg) begin
            e_ack = 1; e_set = 9'd1 << p; m_pend = p; m_ph = P_WAIT; m_left = T;
          end else begin
            e_err = req;
            m_left--;
            if (m_left == 0) begin
              e_to = 1; m_turn ^= 1; m_left = T;
            end
          end
        end
        P_WAIT: begin
          m_cnt++;
          m_ph = P_CHECK;
        end
        P_CHECK: begin
          wl = lines_of(m_turn);
          if (wl != 0) begin
            m_ph = P_DONE; e_over = 1; e_wv = 1; e_w = m_turn[0]; e_wl = wl;
          end else if (m_cnt == 9) begin
            m_ph = P_DONE; e_over = 1;
          end else begin
            m_turn ^= 1; m_ph = P_PLAY;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [28:0] act_vec();
    return {cell_clear, move_ack, move_err, timeout, cell_set, turn, move_count,
            game_over, winner_valid, winner & winner_valid, win_lines};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {(m_ph == P_CLEAR), e_ack, e_err, e_to, e_set, m_turn[0], 4'(m_cnt),
            e_over, e_wv, e_w & e_wv, e_wl};
  endfunction

  // ---------------- table-driven move vectors ----------------
  typedef struct {
    bit         ng;
    logic [3:0] pos;
    bit         ack;
    bit         trn;
    logic [3:0] cnt;
    bit         over;
    bit         wv;
    bit         w;
    logic [7:0] wl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] oh;
    vec_t v;

    // X wins on the top row
    tbl.push_back(vec_t'{0, 4'd0, 1, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd3, 1, 0, 4'd2, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd1, 1, 1, 4'd3, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd4, 1, 0, 4'd4, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd2, 1, 0, 4'd5, 1, 1, 0, 8'h01});
    // illegal moves: occupied cell, index 9, index 15
    tbl.push_back(vec_t'{1, 4'd4, 1, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd4, 0, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd9, 0, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd15, 0, 1, 4'd1, 0, 0, 0, 8'h00});
    // draw
    tbl.push_back(vec_t'{1, 4'd0, 1, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd1, 1, 0, 4'd2, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd2, 1, 1, 4'd3, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd4, 1, 0, 4'd4, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd3, 1, 1, 4'd5, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd5, 1, 0, 4'd6, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd7, 1, 1, 4'd7, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd6, 1, 0, 4'd8, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd8, 1, 0, 4'd9, 1, 0, 0, 8'h00});
    // ninth move completes row 0 and col 2 at once: win beats draw
    tbl.push_back(vec_t'{1, 4'd0, 1, 1, 4'd1, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd3, 1, 0, 4'd2, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd1, 1, 1, 4'd3, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd4, 1, 0, 4'd4, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd5, 1, 1, 4'd5, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd6, 1, 0, 4'd6, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd8, 1, 1, 4'd7, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd7, 1, 0, 4'd8, 0, 0, 0, 8'h00});
    tbl.push_back(vec_t'{0, 4'd2, 1, 0, 4'd9, 1, 1, 0, 8'h21});

    reset = 1'b0; new_game = 1'b0; move_req = 1'b0; move_pos = 4'd0;

    // ---- reset state ----
    tick; tick;
    check("reset_outputs", 64'(act_vec()), 64'({1'b1, 28'd0}));
    reset = 1'b1;
    check("clear_after_release", 64'(cell_clear), 64'd1);
    tick;
    check("play_entry", 64'({cell_clear, turn, move_count}), 64'd0);

    // ---- table of moves ----
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      if (v.ng) begin
        new_game = 1'b1; tick; new_game = 1'b0; tick;
      end
      move_req = 1'b1; move_pos = v.pos;
      tick;
      move_req = 1'b0;
      oh = 16'd1 << v.pos;
      check($sformatf("move%0d_ack", k), 64'({move_ack, move_err, cell_set}),
            64'({v.ack, !v.ack, v.ack ? oh[8:0] : 9'd0}));
      if (v.ack) begin tick; tick; end
      check($sformatf("move%0d_state", k),
            64'({turn, move_count, game_over, winner_valid, winner, win_lines}),
            64'({v.trn, v.cnt, v.over, v.wv, v.w, v.wl}));
    end

    // ---- DONE ignores moves and holds ----
    move_req = 1'b1; move_pos = 4'd9;
    tick; tick;
    move_req = 1'b0;
    check("done_hold", 64'({move_ack, move_err, cell_set, game_over, winner_valid, win_lines, move_count}),
          64'({1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 8'h21, 4'd9}));

    // ---- timeout ----
    new_game = 1'b1; tick; new_game = 1'b0; tick;
    for (int c = 1; c < T; c++) begin
      tick;
      check($sformatf("no_timeout_%0d", c), 64'(timeout), 64'd0);
    end
    tick;
    check("timeout_pulse", 64'({timeout, turn, move_count}), 64'({1'b1, 1'b1, 4'd0}));
    tick;
    check("timeout_one_cycle", 64'(timeout), 64'd0);
    for (int c = 2; c < T; c++) tick;
    move_req = 1'b1; move_pos = 4'd0;
    tick;
    move_req = 1'b0;
    check("move_beats_timeout", 64'({move_ack, timeout}), 64'({1'b1, 1'b0}));
    tick; tick;
    check("after_late_move", 64'({turn, move_count, cell_valid[0], cell_symbol[0]}),
          64'({1'b0, 4'd1, 1'b1, 1'b1}));

    // ---- new_game during WAIT ----
    move_req = 1'b1; move_pos = 4'd1;
    tick;
    move_req = 1'b0;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    check("ng_wait_clear", 64'({cell_clear, turn, move_count, cell_set}), 64'({1'b1, 1'b0, 4'd0, 9'd0}));
    tick;
    check("ng_wait_cells", 64'({cell_clear, cell_valid}), 64'd0);

    // ---- asynchronous reset in CHECK ----
    move_req = 1'b1; move_pos = 4'd4;
    tick;
    move_req = 1'b0;
    tick;
    check("pre_reset_count", 64'(move_count), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'(act_vec()), 64'({1'b1, 28'd0}));
    tick;
    reset = 1'b1;
    check("clear_held_release", 64'(cell_clear), 64'd1);
    tick;
    check("clear_dropped", 64'(cell_clear), 64'd0);

    // ---- randomized run against the reference model ----
    reset = 1'b0;
    tick; tick;
    model_reset();
    reset = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      bit ng, rq;
      logic [3:0] ps;
      ng = ($urandom_range(0, 59) == 0);
      rq = ($urandom_range(0, 2) == 0);
      ps = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      new_game = ng; move_req = rq; move_pos = ps;
      tick;
      model_edge(ng, rq, ps);
      check($sformatf("rand%0d", n), 64'(act_vec()), 64'(exp_vec()));
    end
    new_game = 1'b0; move_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
